// File: rtl/toggle_delay_pipe.sv
// Multi-channel toggle/load register with a DEPTH-stage enabled delay line,
// a free-running OR_LAT-stage pipeline on (x | y), fill status and change count.
module toggle_delay_pipe #(
  parameter int unsigned       WIDTH     = 4,
  parameter int unsigned       DEPTH     = 1,
  parameter int unsigned       OR_LAT    = 1,
  parameter int unsigned       CNT_W     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] x_q,
  output logic [WIDTH-1:0] y_q,
  output logic             y_valid,
  output logic [WIDTH-1:0] out_or,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  x_d;
  logic [WIDTH-1:0]  dly_q [DEPTH];
  logic [WIDTH-1:0]  dly_d [DEPTH];
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [CNT_W-1:0]  chg_cnt_q;
  logic [CNT_W-1:0]  chg_cnt_d;

  always_comb begin
    x_d       = x_q;
    fill_d    = fill_q;
    chg_cnt_d = chg_cnt_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      dly_d[k] = dly_q[k];
    end

    if (en) begin
      x_d      = mode ? load_val : ~x_q;
      // every stage takes its predecessor's pre-edge value
      dly_d[0] = x_q;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        dly_d[k] = dly_q[k-1];
      end
      if (fill_q != FILL_W'(DEPTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end
      if ((x_d != x_q) && (chg_cnt_q != '1)) begin
        chg_cnt_d = chg_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= RESET_VAL;
      fill_q    <= '0;
      chg_cnt_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      x_q       <= x_d;
      fill_q    <= fill_d;
      chg_cnt_q <= chg_cnt_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dly_q[k] <= dly_d[k];
      end
    end
  end

  assign y_q     = dly_q[DEPTH-1];
  assign y_valid = (fill_q == FILL_W'(DEPTH));
  assign chg_cnt = chg_cnt_q;

  generate
    if (OR_LAT == 0) begin : g_or_comb
      assign out_or = x_q | y_q;
    end else begin : g_or_pipe
      // free-running: samples every edge regardless of en
      logic [WIDTH-1:0] or_q [OR_LAT];
      logic [WIDTH-1:0] or_d [OR_LAT];

      always_comb begin
        or_d[0] = x_q | y_q;
        for (int unsigned k = 1; k < OR_LAT; k++) begin
          or_d[k] = or_q[k-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < OR_LAT; k++) begin
            or_q[k] <= '0;
          end
        end else begin
          for (int unsigned k = 0; k < OR_LAT; k++) begin
            or_q[k] <= or_d[k];
          end
        end
      end

      assign out_or = or_q[OR_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_toggle_delay_pipe.sv
// Scoreboard bench for toggle_delay_pipe: three configurations share one
// stimulus stream; a history-based model predicts every output after each edge.
module tb_toggle_delay_pipe;

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    logic        v;
    logic [3:0]  o;
    int unsigned cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [3:0] load_val;

  logic [3:0] x_o   [3];
  logic [3:0] y_o   [3];
  logic       v_o   [3];
  logic [3:0] o_o   [3];
  logic [7:0] cnt_a;
  logic [2:0] cnt_b;
  logic [7:0] cnt_c;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // a: DEPTH=2/OR_LAT=1, b: same with 3-bit counter, c: DEPTH=1/OR_LAT=0
  int unsigned dep_c [3] = '{2, 2, 1};
  int unsigned lat_c [3] = '{1, 1, 0};
  int unsigned cap_c [3] = '{255, 7, 255};

  int unsigned m_edges;
  int unsigned m_ne;
  logic [3:0]  m_x;
  logic [3:0]  xs   [1024];
  logic [3:0]  comb [3][1024];
  int unsigned m_cnt [3];

  exp_t sb0 [$];
  exp_t sb1 [$];
  exp_t sb2 [$];

  always #5 clk = ~clk;

  toggle_delay_pipe #(.WIDTH(4), .DEPTH(2), .OR_LAT(1), .CNT_W(8), .RESET_VAL(4'h0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_val(load_val),
    .x_q(x_o[0]), .y_q(y_o[0]), .y_valid(v_o[0]), .out_or(o_o[0]), .chg_cnt(cnt_a));

  toggle_delay_pipe #(.WIDTH(4), .DEPTH(2), .OR_LAT(1), .CNT_W(3), .RESET_VAL(4'h0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_val(load_val),
    .x_q(x_o[1]), .y_q(y_o[1]), .y_valid(v_o[1]), .out_or(o_o[1]), .chg_cnt(cnt_b));

  toggle_delay_pipe #(.WIDTH(4), .DEPTH(1), .OR_LAT(0), .CNT_W(8), .RESET_VAL(4'h0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_val(load_val),
    .x_q(x_o[2]), .y_q(y_o[2]), .y_valid(v_o[2]), .out_or(o_o[2]), .chg_cnt(cnt_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0:       return 32'(cnt_a);
      1:       return 32'(cnt_b);
      default: return 32'(cnt_c);
    endcase
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_ne    = 0;
    m_x     = 4'h0;
    xs[0]   = m_x;
    for (int i = 0; i < 3; i++) begin
      comb[i][0] = m_x;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic reset_checks(input string when);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.%0d.x_q", when, i),     32'(x_o[i]), 32'h0);
      check($sformatf("%s.%0d.y_q", when, i),     32'(y_o[i]), 32'h0);
      check($sformatf("%s.%0d.y_valid", when, i), 32'(v_o[i]), 32'h0);
      check($sformatf("%s.%0d.out_or", when, i),  32'(o_o[i]), 32'h0);
      check($sformatf("%s.%0d.chg_cnt", when, i), dut_cnt(i),  32'h0);
    end
  endtask

  task automatic compare_one(input int i, input exp_t ex);
    check($sformatf("e%0d.%0d.x_q", m_edges, i),     32'(x_o[i]), 32'(ex.x));
    check($sformatf("e%0d.%0d.y_q", m_edges, i),     32'(y_o[i]), 32'(ex.y));
    check($sformatf("e%0d.%0d.y_valid", m_edges, i), 32'(v_o[i]), 32'(ex.v));
    check($sformatf("e%0d.%0d.out_or", m_edges, i),  32'(o_o[i]), 32'(ex.o));
    check($sformatf("e%0d.%0d.chg_cnt", m_edges, i), dut_cnt(i),  ex.cnt);
  endtask

  // drive one edge's inputs, predict the post-edge outputs, then compare
  task automatic step(input logic e, input logic md, input logic [3:0] lv);
    exp_t       ex;
    logic [3:0] nx;
    en       = e;
    mode     = md;
    load_val = lv;
    m_edges++;
    if (e) begin
      nx = md ? lv : ~m_x;
      for (int i = 0; i < 3; i++) begin
        if (nx != m_x && m_cnt[i] < cap_c[i]) m_cnt[i]++;
      end
      m_ne++;
      m_x      = nx;
      xs[m_ne] = m_x;
    end
    for (int i = 0; i < 3; i++) begin
      ex.x   = m_x;
      ex.y   = (m_ne >= dep_c[i]) ? xs[m_ne - dep_c[i]] : 4'h0;
      ex.v   = (m_ne >= dep_c[i]);
      comb[i][m_edges] = ex.x | ex.y;
      ex.o   = (m_edges >= lat_c[i]) ? comb[i][m_edges - lat_c[i]] : 4'h0;
      ex.cnt = m_cnt[i];
      case (i)
        0:       sb0.push_back(ex);
        1:       sb1.push_back(ex);
        default: sb2.push_back(ex);
      endcase
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      int unsigned depth_now;
      depth_now = (i == 0) ? sb0.size() : (i == 1) ? sb1.size() : sb2.size();
      check($sformatf("sb%0d.avail", i), 32'(depth_now != 0), 32'h1);
      if (depth_now != 0) begin
        case (i)
          0:       ex = sb0.pop_front();
          1:       ex = sb1.pop_front();
          default: ex = sb2.pop_front();
        endcase
        compare_one(i, ex);
      end
    end
  endtask

  task automatic scenario_toggle4();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    load_val = 4'h0;
    model_reset();
    #2;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    // toggle from reset: x F/0/F, y 0/0/F, out_or F after edge 4
    scenario_toggle4();

    // stall with mode/load_val wiggling: everything but out_or holds
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b0, 4'h9);
    step(1'b0, 1'b1, 4'hC);

    // load equal value (no count), then a new value
    step(1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b1, 4'h5);

    // long toggle run pushes the 3-bit counter into saturation
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'h0);

    // short async reset pulse between edges
    #1;
    rst_n = 1'b0;
    #2;
    reset_checks("mid");
    #1;
    rst_n = 1'b1;
    model_reset();

    scenario_toggle4();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 4'h0);

    for (int k = 0; k < 30; k++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    check("sb_drained", 32'(sb0.size() + sb1.size() + sb2.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_delay_pipe.md
Name: toggle_delay_pipe

Overview:
Parametrised multi-channel toggle/delay pipeline with a latency-programmable OR output. Each channel holds a toggle-or-load register x and a DEPTH-stage delayed copy y. The block drives a registered OR of x and y, plus fill and change-count status. It is the generalised successor of our single-bit toggle/shift/delayed-OR stimulus structure and serves as a reusable scheduling and latency checker in simulation tops.

Parameters:
WIDTH, 4, number of independent channels (>=1)
DEPTH, 1, delay-line stages from x to y (>=1)
OR_LAT, 1, register stages on out_or (>=0; 0 = combinational)
CNT_W, 8, width of chg_cnt (>=1)
RESET_VAL, {WIDTH{1'b0}}, reset value of x_q

Ports:
clk  input  1  single clock, all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
en  input  1  advance x/delay-line/fill/count when 1; hold when 0
mode  input  1  0 = toggle x (x <= ~x), 1 = load x from load_val
load_val  input  WIDTH  value loaded into x when en=1 and mode=1
x_q  output  WIDTH  current channel register
y_q  output  WIDTH  x_q delayed by DEPTH enabled cycles
y_valid  output  1  1 once DEPTH enabled cycles have elapsed since reset
out_or  output  WIDTH  (x_q | y_q) delayed OR_LAT clocks
chg_cnt  output  CNT_W  saturating count of enabled cycles where x changed

Behaviour:
- Reset (rst_n=0, async, takes effect immediately with no clock edge): x_q=RESET_VAL; all delay stages, y_q and out_or stages = 0; y_valid=0; chg_cnt=0. Reset asserted mid-operation discards all in-flight values.
- Delay line d[0..DEPTH-1]: on an en=1 edge, d[0] <= old x_q and d[k] <= d[k-1]; y_q = d[DEPTH-1]. With DEPTH=1 this is the classic y <= x nonblocking shift. All non-blocking: every stage samples pre-edge values.
- x update on an en=1 edge: x_q <= mode ? load_val : ~x_q. With en=0, x_q, the delay line, the fill counter and chg_cnt hold.
- Fill: an internal counter increments on en=1 edges and saturates at DEPTH. y_valid = (fill == DEPTH). y_q still reads 0 before valid.
- out_or pipeline is free-running and ignores en. Stage 0 samples (x_q | y_q) every edge; OR_LAT stages in series; out_or at edge t+OR_LAT equals x_q|y_q present just before edge t+1. With OR_LAT=0, out_or = x_q | y_q combinationally.
- chg_cnt: on an en=1 edge where next x differs from x_q in any bit, chg_cnt increments. It saturates at 2^CNT_W-1 and never wraps. A toggle always counts; a load of an equal value does not.
- mode and load_val are sampled only on en=1 edges; changes while en=0 have no effect.
- No X propagation: all state is reset; load_val X while mode=1,en=1 is a bench error.

Test Plan:
1. WIDTH=4, DEPTH=2, OR_LAT=1, RESET_VAL=0; release reset, en=1, mode=0 -> x_q after edges 1/2/3 = F/0/F. y_q = 0/0/F. y_valid=1 from edge 2. out_or after edge 4 = F. chg_cnt = 3 after edge 3.
2. Same config after scenario 1, drop en for 3 edges -> x_q, y_q, chg_cnt held. out_or settles to x_q|y_q one edge after the stall begins and stays constant.
3. mode=1, en=1, load_val=A while x_q=A -> x_q=A, chg_cnt unchanged. Next load_val=5 -> x_q=5, chg_cnt+1, and y_q=5 two enabled edges later.
4. CNT_W=3, mode=0, en=1 for 10 edges -> chg_cnt reads 1..7 then holds 7.
5. Mid-run, pulse rst_n low between edges for 3 ns -> x_q=RESET_VAL, y_q=0, out_or=0, y_valid=0, chg_cnt=0 immediately. After release, the sequence repeats scenario 1 exactly.
6. OR_LAT=0, DEPTH=1 -> out_or equals x_q|y_q in the same cycle. With toggling, x_q=F,y_q=0 gives out_or=F; x_q=0,y_q=F gives out_or=F.
